// File: rtl/accu_pkg.sv
// Shared constants and types for the accumulator pipeline.
//   SUM_W : width of the 4-beat sum from the accumulator
//   AVG_W : width of the stored / delivered mean
package accu_pkg;

  localparam int unsigned SUM_W = 10;
  localparam int unsigned AVG_W = 8;

  typedef logic [AVG_W-1:0] avg_t;

endpackage

// File: rtl/accu_avg_fifo.sv
// Small circular FIFO of means sitting behind the output register.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   wr, wdata  write strobe and mean to store (caller guarantees !full)
//   rd         pop strobe (caller guarantees !empty)
//   rdata      current head entry (combinational read of the head slot)
//   level      entries held, 0..DEPTH
//   full/empty status decoded from level
module accu_avg_fifo
  import accu_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned LW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr,
  input  avg_t          wdata,
  input  logic          rd,
  output avg_t          rdata,
  output logic [LW-1:0] level,
  output logic          full,
  output logic          empty
);

  avg_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // Pointers wrap naturally at DEPTH (power of two); level is a separate counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + AW'(1);
      if (rd) rd_ptr <= rd_ptr + AW'(1);
      if (wr && !rd)      level <= level + LW'(1);
      else if (!wr && rd) level <= level - LW'(1);
    end
  end

  // Storage needs no reset: contents are only visible through level.
  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
  assign full  = (level == LW'(DEPTH));
  assign empty = (level == '0);

endmodule

// File: rtl/accu_avg_buf.sv
// Mean buffer behind the 4-beat accumulator: converts each 10-bit sum to an
// 8-bit mean, buffers it and delivers it through a registered output stage.
// Build option: ACCU_AVG_ROUND_EN selects round-half-up mean, else truncation.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   data_in, valid_a  sum from accumulator and its valid
//   ready_a           space available (decoded from registered FIFO level)
//   data_out, valid_b registered mean and valid toward the consumer
//   ready_b           consumer accepts data_out
//   level             entries held in the FIFO, excluding the output register
module accu_avg_buf
  import accu_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SUM_W-1:0] data_in,
  input  logic             valid_a,
  output logic             ready_a,
  output logic             valid_b,
  input  logic             ready_b,
  output logic [AVG_W-1:0] data_out,
  output logic [AW:0]      level
);

  // Mean of four samples; max sum 1020 keeps the result within 8 bits.
  function automatic avg_t mean(input logic [SUM_W-1:0] sum);
`ifdef ACCU_AVG_ROUND_EN
    mean = avg_t'(({1'b0, sum} + 11'd2) >> 2);
`else
    mean = avg_t'(sum >> 2);
`endif
  endfunction

  logic push;
  logic load;
  logic fifo_wr;
  logic fifo_rd;
  logic full;
  logic empty;
  avg_t head;
  avg_t mean_in;

  assign mean_in = mean(data_in);
  assign ready_a = !full;
  assign push    = valid_a && ready_a;
  assign load    = !valid_b || ready_b;

  // FIFO control: the head feeds the output first; an accepted beat bypasses
  // the FIFO only when it is empty and the output register can load.
  always_comb begin
    fifo_rd = 1'b0;
    fifo_wr = push;
    if (load && !empty) fifo_rd = 1'b1;
    else if (load && push) fifo_wr = 1'b0;
  end

  accu_avg_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .wr    (fifo_wr),
    .wdata (mean_in),
    .rd    (fifo_rd),
    .rdata (head),
    .level (level),
    .full  (full),
    .empty (empty)
  );

  // Output register: holds under back-pressure, otherwise head > bypass > idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_b  <= 1'b0;
      data_out <= '0;
    end else if (load) begin
      if (!empty) begin
        valid_b  <= 1'b1;
        data_out <= head;
      end else if (push) begin
        valid_b  <= 1'b1;
        data_out <= mean_in;
      end else begin
        valid_b  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_accu_avg_buf.sv
`timescale 1ns/1ps
module tb_accu_avg_buf;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          rst;
  logic [9:0]    data_in;
  logic          valid_a;
  logic          ready_a;
  logic          valid_b;
  logic          ready_b;
  logic [7:0]    data_out;
  logic [AW:0]   level;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_q[$];
  bit hold     = 1'b0;
  int hold_data = 0;
  bit rnd_done;

  always #5 clk = ~clk;

  accu_avg_buf #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .data_in  (data_in),
    .valid_a  (valid_a),
    .ready_a  (ready_a),
    .valid_b  (valid_b),
    .ready_b  (ready_b),
    .data_out (data_out),
    .level    (level)
  );

  // Reference mean straight from the arithmetic definition.
  function automatic int mean_of(input int v);
`ifdef ACCU_AVG_ROUND_EN
    return (v + 2) / 4;
`else
    return v / 4;
`endif
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Offer one beat; record its expected mean when the handshake completes.
  task automatic send(input int v);
    int  n;
    bit  acc;
    n = 0;
    valid_a = 1'b1;
    data_in = 10'(v);
    forever begin
      @(negedge clk);
      acc = ready_a;
      @(posedge clk);
      if (acc) begin
        exp_q.push_back(mean_of(v));
        break;
      end
      n++;
      if (n > 200) begin
        n_checks++;
        n_fail++;
        $display("FAIL send_timeout: beat %0d not accepted after %0d cycles", v, n);
        break;
      end
    end
    #1 valid_a = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || valid_b) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_outstanding", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // Monitor: scoreboard pops on every output handshake; also checks
  // back-pressure stability and the ready/level relationship.
  always @(negedge clk) begin
    if (rst) begin
      hold = 1'b0;
    end else begin
      chk("ready_a_vs_level", int'(ready_a), int'(level != DEPTH));
      if (level > DEPTH) chk("level_range", int'(level), DEPTH);
      if (hold) begin
        chk("hold_valid", int'(valid_b), 1);
        chk("hold_data", int'(data_out), hold_data);
      end
      if (valid_b && ready_b) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output: got %0d expected none at %0t", data_out, $time);
        end else begin
          chk("data_out_order", int'(data_out), exp_q.pop_front());
        end
      end
      hold      = valid_b && !ready_b;
      hold_data = int'(data_out);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a;
    rst     = 1'b1;
    valid_a = 1'b0;
    data_in = '0;
    ready_b = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_valid_b", int'(valid_b), 0);
    chk("reset_data_out", int'(data_out), 0);
    chk("reset_level", int'(level), 0);
    chk("reset_ready_a", int'(ready_a), 1);
    @(posedge clk);
    #1 rst = 1'b0;

    // Bypass: empty FIFO, consumer ready -> mean visible one cycle later.
    ready_b = 1'b1;
    send(400);
    @(negedge clk);
    chk("bypass_valid", int'(valid_b), 1);
    chk("bypass_data", int'(data_out), 100);
    chk("bypass_level", int'(level), 0);
    drain();

    // Back-pressure: fill output register plus FIFO.
    ready_b = 1'b0;
    send(4); send(8); send(12); send(16); send(20);
    @(negedge clk);
    chk("full_level", int'(level), 4);
    chk("full_ready_a", int'(ready_a), 0);
    chk("full_valid_b", int'(valid_b), 1);
    chk("full_data_out", int'(data_out), 1);
    valid_a = 1'b1;
    data_in = 10'd24;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("held_off_ready_a", int'(ready_a), 0);
      chk("held_off_level", int'(level), 4);
    end

    // Release: five means on consecutive cycles, ready_a back after first pop.
    @(posedge clk);
    #1 ready_b = 1'b1;
    fork
      send(24);
      begin
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          chk("release_valid", int'(valid_b), 1);
          chk("release_data", int'(data_out), i + 1);
          if (i == 1) chk("release_ready_a", int'(ready_a), 1);
        end
      end
    join
    drain();

    // Simultaneous push and pop with level 2.
    ready_b = 1'b0;
    send($urandom_range(0, 1020));
    send($urandom_range(0, 1020));
    send($urandom_range(0, 1020));
    @(negedge clk);
    chk("pushpop_pre_level", int'(level), 2);
    @(posedge clk);
    #1 ready_b = 1'b1;
    send($urandom_range(0, 1020));
    @(negedge clk);
    chk("pushpop_level", int'(level), 2);
    drain();

    // Top-of-range sums.
    ready_b = 1'b1;
    send(1018);
    send(1020);
    send(0);
    send(3);
    drain();

    // Randomized traffic with random consumer back-pressure.
    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          send($urandom_range(0, 1020));
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1 ready_b = ($urandom_range(0, 99) < 45);
        end
      end
    join
    ready_b = 1'b1;
    drain();

    // Asynchronous reset while an output is pending.
    ready_b = 1'b0;
    send(200);
    send(300);
    @(posedge clk);
    #2 rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("midreset_valid_b", int'(valid_b), 0);
    chk("midreset_data_out", int'(data_out), 0);
    chk("midreset_level", int'(level), 0);
    chk("midreset_ready_a", int'(ready_a), 1);
    @(posedge clk);
    #1 rst = 1'b0;
    ready_b = 1'b1;
    send(40);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
